// File: rtl/ts3d_psum_pkg.sv
// Shared types and sizing for the PSUM global-buffer read-back path.
package ts3d_psum_pkg;

  localparam int LANES       = 16;
  localparam int PSUM_W      = 32;
  localparam int PSUM_ADDR_W = 10;
  localparam int PSUM_LEN_W  = 10;

  // One beat: lane i lives at [PSUM_W*i +: PSUM_W]
  typedef logic [LANES*PSUM_W-1:0] psum_beat_t;

  // Burst sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/psum_skid_fifo.sv
// Two-entry skid FIFO that absorbs the SRAM read latency in front of the PEB.
module psum_skid_fifo
  import ts3d_psum_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  psum_beat_t push_data,
  input  logic       pop,
  output logic [1:0] cnt,
  output psum_beat_t head
);

  psum_beat_t tail;
  logic       do_pop;
  logic       do_push;

  // A pop on an empty FIFO is meaningless; a push into a full FIFO is only legal alongside a pop
  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  // Head/tail storage and occupancy; head is always the oldest entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) head <= push_data;
          else             tail <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/psum_gb_reader.sv
// PSUM read-back source: turns a burst command into SRAM reads and streams beats to one PEB.
module psum_gb_reader
  import ts3d_psum_pkg::*;
#(
  parameter int ADDR_W = PSUM_ADDR_W,
  parameter int LEN_W  = PSUM_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_val,
  output logic              cmd_rdy,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_zero,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  psum_beat_t        mem_rd_data,
  output logic              GBPSUM_val,
  output psum_beat_t        GBPSUM_data,
  input  logic              PSUMGB_rdy,
  output logic              busy,
  output logic              done
);

  localparam logic [LEN_W:0] ONE = 1;

  rd_state_e         state;
  rd_state_e         state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic              zero_q;
  logic [LEN_W:0]    issued;
  logic [LEN_W:0]    sent;
  logic              inflight;
  logic [1:0]        fifo_cnt;
  psum_beat_t        fifo_head;
  psum_beat_t        push_data;
  logic              cmd_acc;
  logic              push;
  logic              pop;
  logic              issue;
  logic              last_pop;
  logic [2:0]        credit_used;

  assign cmd_acc    = cmd_val && cmd_rdy;
  assign GBPSUM_val = (fifo_cnt != 2'd0);
  assign GBPSUM_data = fifo_head;
  assign pop        = GBPSUM_val && PSUMGB_rdy;

  // Credit counts the slot freed by this cycle's pop so a 1-cycle-latency SRAM can sustain one beat per cycle
  assign credit_used = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue       = (state == RUN) && (issued < {1'b0, len_q}) && (credit_used < 3'd2);

  assign mem_rd_en   = issue && !zero_q;
  assign mem_rd_addr = base_q + ADDR_W'(issued);

  // SRAM data lands one cycle after the strobe; zero-fill beats enter on the issue cycle itself
  assign push      = inflight || (issue && zero_q);
  assign push_data = inflight ? mem_rd_data : '0;
  assign last_pop  = pop && (sent == ({1'b0, len_q} - ONE));

  psum_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .cnt       (fifo_cnt),
    .head      (fifo_head)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the handshake/status outputs decoded from the state
  always_comb begin
    state_nxt = state;
    cmd_rdy   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_val) state_nxt = (cmd_len == '0) ? FIN : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_pop) state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command fields are captured once at accept so the source may change them afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      zero_q <= 1'b0;
    end else if (cmd_acc) begin
      base_q <= cmd_base;
      len_q  <= cmd_len;
      zero_q <= cmd_zero;
    end
  end

  // Issued/sent beat counters and the one-deep record of an outstanding SRAM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued   <= '0;
      sent     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_rd_en;
      if (cmd_acc) begin
        issued <= '0;
        sent   <= '0;
      end else begin
        if (issue) issued <= issued + ONE;
        if (pop)   sent   <= sent + ONE;
      end
    end
  end

endmodule

// File: tb/tb_psum_gb_reader.sv
// Self-checking bench for psum_gb_reader: table of bursts, a mid-burst reset, then random bursts.
module tb_psum_gb_reader;
  import ts3d_psum_pkg::*;

  localparam int AW = PSUM_ADDR_W;
  localparam int LW = PSUM_LEN_W;

  // Cycle numbering inside a burst: cycle 0 is the cycle whose closing edge accepts the command
  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    logic          zero;
    int            mode;
    int            exp_reads;
    int            exp_first;
    int            exp_done;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_val = 1'b0;
  logic          cmd_rdy;
  logic [AW-1:0] cmd_base = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_zero = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  psum_beat_t    mem_rd_data = '0;
  logic          GBPSUM_val;
  psum_beat_t    GBPSUM_data;
  logic          PSUMGB_rdy = 1'b0;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  psum_beat_t sram [1<<AW];
  logic       rd_pend = 1'b0;
  psum_beat_t rd_pend_data = '0;
  vec_t       vectors [8];

  psum_gb_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_val     (cmd_val),
    .cmd_rdy     (cmd_rdy),
    .cmd_base    (cmd_base),
    .cmd_len     (cmd_len),
    .cmd_zero    (cmd_zero),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .GBPSUM_val  (GBPSUM_val),
    .GBPSUM_data (GBPSUM_data),
    .PSUMGB_rdy  (PSUMGB_rdy),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_cmd_rdy"}, cmd_rdy, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_val"}, GBPSUM_val, 0);
    checkOutput({tag, "_data"}, GBPSUM_data, 0);
    checkOutput({tag, "_rd_en"}, mem_rd_en, 0);
    checkOutput({tag, "_rd_addr"}, mem_rd_addr, 0);
  endtask

  function automatic logic rdyFor(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 3 == 0);
    return ($urandom_range(0, 3) != 0);
  endfunction

  // One clock: deliver last cycle's SRAM read, drive ready, then settle for sampling
  task automatic stepCycle(input logic rdy_val);
    @(negedge clk);
    if (rd_pend) begin
      mem_rd_data = rd_pend_data;
      rd_pend = 1'b0;
    end
    PSUMGB_rdy = rdy_val;
    #1;
  endtask

  task automatic noteRead();
    if (mem_rd_en) begin
      rd_pend = 1'b1;
      rd_pend_data = sram[mem_rd_addr];
    end
  endtask

  // Run one burst to completion, checking every read address and beat against the expected queues
  task automatic applyStimulus(input vec_t v);
    psum_beat_t    exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [AW-1:0] a;
    psum_beat_t    prev_data = '0;
    logic          prev_stall = 1'b0;
    int reads = 0, pops = 0, dones = 0, first_val = -1, done_cyc = -1;
    int limit = int'(v.len) * 4 + 40;
    bit finished = 0;
    for (int k = 0; k < int'(v.len); k++) begin
      a = AW'(int'(v.base) + k);
      addr_q.push_back(a);
      exp_q.push_back(v.zero ? '0 : sram[a]);
    end
    for (int c = 0; c <= limit && !finished; c++) begin
      stepCycle(rdyFor(v.mode, c));
      if (c == 0) begin
        checkOutput("cmd_rdy_idle", cmd_rdy, 1);
        cmd_base = v.base;
        cmd_len  = v.len;
        cmd_zero = v.zero;
        cmd_val  = 1'b1;
      end else begin
        if (c == 1) begin
          cmd_val  = 1'b0;
          cmd_base = AW'($urandom);
          cmd_len  = LW'($urandom);
          cmd_zero = 1'($urandom);
          checkOutput("busy_after_accept", busy, 1);
          checkOutput("cmd_rdy_busy", cmd_rdy, 0);
        end
        if (mem_rd_en) begin
          reads++;
          if (addr_q.size() == 0) checkOutput("rd_extra", 1, 0);
          else checkOutput("rd_addr", mem_rd_addr, addr_q.pop_front());
        end
        if (GBPSUM_val) begin
          if (first_val < 0) first_val = c;
          if (prev_stall) checkOutput("stall_data", GBPSUM_data, prev_data);
          if (exp_q.size() == 0) checkOutput("stale_beat", 1, 0);
          else if (PSUMGB_rdy) begin
            checkOutput("beat_data", GBPSUM_data, exp_q.pop_front());
            pops++;
          end
        end else if (prev_stall) begin
          checkOutput("stall_val", GBPSUM_val, 1);
        end
        prev_stall = GBPSUM_val && !PSUMGB_rdy;
        prev_data  = GBPSUM_data;
        checkOutput("credit", ((reads - pops) <= 2), 1);
        if (done_cyc >= 0 && c == done_cyc + 1) begin
          checkOutput("cmd_rdy_after_done", cmd_rdy, 1);
          checkOutput("busy_after_done", busy, 0);
          checkOutput("done_width", done, 0);
          finished = 1;
        end else if (done) begin
          dones++;
          if (done_cyc < 0) done_cyc = c;
        end
      end
      noteRead();
    end
    checkOutput("done_count", dones, 1);
    checkOutput("read_count", reads, v.exp_reads);
    checkOutput("beats_left", exp_q.size(), 0);
    if (v.exp_first > 0) checkOutput("first_val_cycle", first_val, v.exp_first);
    if (v.exp_done > 0)  checkOutput("done_cycle", done_cyc, v.exp_done);
  endtask

  // Two beats of a burst, then reset: everything must snap back and no done may pulse
  task automatic resetMidBurst();
    int pops = 0;
    stepCycle(1'b1);
    cmd_base = AW'(50);
    cmd_len  = LW'(5);
    cmd_zero = 1'b0;
    cmd_val  = 1'b1;
    for (int c = 1; c <= 20 && pops < 2; c++) begin
      stepCycle(1'b1);
      if (c == 1) cmd_val = 1'b0;
      if (GBPSUM_val) begin
        checkOutput("rst_pre_beat", GBPSUM_data, sram[AW'(50 + pops)]);
        pops++;
      end
      noteRead();
    end
    checkOutput("rst_pre_pops", pops, 2);
    @(negedge clk);
    rst_n = 1'b0;
    rd_pend = 1'b0;
    #1;
    checkReset("midrst");
    stepCycle(1'b1);
    checkReset("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t rv;
    $display("[TB] start");
    for (int a = 0; a < (1 << AW); a++)
      for (int l = 0; l < LANES; l++)
        sram[a][l*PSUM_W +: PSUM_W] = $urandom;

    vectors[0] = '{base: AW'(5),    len: LW'(4),    zero: 1'b0, mode: 0, exp_reads: 4,    exp_first: 3, exp_done: 7};
    vectors[1] = '{base: AW'(0),    len: LW'(3),    zero: 1'b1, mode: 0, exp_reads: 0,    exp_first: 2, exp_done: 5};
    vectors[2] = '{base: AW'(100),  len: LW'(6),    zero: 1'b0, mode: 1, exp_reads: 6,    exp_first: 3, exp_done: 0};
    vectors[3] = '{base: AW'(1022), len: LW'(4),    zero: 1'b0, mode: 0, exp_reads: 4,    exp_first: 3, exp_done: 7};
    vectors[4] = '{base: AW'(17),   len: LW'(0),    zero: 1'b0, mode: 0, exp_reads: 0,    exp_first: 0, exp_done: 1};
    vectors[5] = '{base: AW'(300),  len: LW'(1),    zero: 1'b0, mode: 0, exp_reads: 1,    exp_first: 3, exp_done: 4};
    vectors[6] = '{base: AW'(9),    len: LW'(5),    zero: 1'b1, mode: 1, exp_reads: 0,    exp_first: 2, exp_done: 0};
    vectors[7] = '{base: AW'(1000), len: LW'(1023), zero: 1'b0, mode: 0, exp_reads: 1023, exp_first: 3, exp_done: 1026};

    repeat (2) @(negedge clk);
    #1;
    checkReset("por");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) applyStimulus(vectors[i]);

    resetMidBurst();
    rv = '{base: AW'(60), len: LW'(3), zero: 1'b0, mode: 0, exp_reads: 3, exp_first: 3, exp_done: 6};
    applyStimulus(rv);

    for (int i = 0; i < 25; i++) begin
      rv.base = AW'($urandom);
      rv.len  = ($urandom_range(0, 7) == 0) ? LW'(0) : LW'($urandom_range(1, 12));
      rv.zero = 1'($urandom_range(0, 1));
      rv.mode = 2;
      rv.exp_reads = rv.zero ? 0 : int'(rv.len);
      rv.exp_first = 0;
      rv.exp_done  = 0;
      applyStimulus(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
